// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state encoding, defaults and bounds for the SPI master arbiter
package spi_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } arb_state_t;

    localparam int DATA_W_DEFAULT = 8;
    localparam int N_REQ_MIN      = 2;
    localparam int N_REQ_MAX      = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// rtl/spi_rr_pick.sv - combinational round-robin picker: first requester after ptr, cyclically
module spi_rr_pick
    import spi_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int            cand;
    logic [IW-1:0] cand_idx;

    // Scan from ptr+1 around to ptr itself; the first hit wins.
    always_comb begin
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = int'(ptr) + off;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = IW'(cand);
            if (!any && req[cand_idx]) begin
                any           = 1'b1;
                idx           = cand_idx;
                gnt[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// rtl/spi_master_arbiter.sv - round-robin arbiter sharing one spi_master_driver; SPI_ARB_WATCHDOG_EN adds a stuck-busy watchdog
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = 1023
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        last_i,
    input  logic [N_REQ*DATA_W-1:0] data_in_bi,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        done_o,
    output logic [DATA_W-1:0]       data_out_bo,
    output logic                    err_o,
    output logic                    spi_start_o,
    output logic [DATA_W-1:0]       spi_data_bo,
    input  logic                    spi_busy_i,
    input  logic [DATA_W-1:0]       spi_data_bi
);

    localparam int IW = idx_width(N_REQ);

    if (N_REQ < N_REQ_MIN || N_REQ > N_REQ_MAX || TIMEOUT < 1) begin : g_param_check
        $error("spi_master_arbiter: parameter out of range");
    end

    arb_state_t        state_q, state_d;
    logic [N_REQ-1:0]  gnt_d, done_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     lock_idx_q, lock_idx_d;
    logic              lock_q, lock_d;
    logic              last_q, last_d;
    logic              start_d;
    logic [DATA_W-1:0] tx_d, rx_d;

    logic [N_REQ-1:0]  lock_mask, lock_gnt, norm_gnt, win_gnt;
    logic [IW-1:0]     lock_win, norm_win, win_idx, pick_ptr;
    logic              lock_any, norm_any, win_any, lock_drop;
    logic              wd_hit;

    // A locked owner that stops requesting hands the pointer to itself, so the
    // normal path in the same cycle starts just after it.
    assign lock_mask = lock_q ? (N_REQ'(1) << lock_idx_q) : '0;
    assign lock_drop = lock_q && !req_i[lock_idx_q];
    assign pick_ptr  = lock_drop ? lock_idx_q : ptr_q;

    spi_rr_pick #(.N_REQ(N_REQ)) u_pick_lock (
        .req (req_i & lock_mask),
        .ptr (ptr_q),
        .gnt (lock_gnt),
        .idx (lock_win),
        .any (lock_any)
    );

    spi_rr_pick #(.N_REQ(N_REQ)) u_pick_norm (
        .req (req_i),
        .ptr (pick_ptr),
        .gnt (norm_gnt),
        .idx (norm_win),
        .any (norm_any)
    );

    assign win_gnt = lock_any ? lock_gnt : norm_gnt;
    assign win_idx = lock_any ? lock_win : norm_win;
    assign win_any = lock_any | norm_any;

`ifdef SPI_ARB_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] wd_q;
    logic          err_q;

    assign wd_hit = (state_q != ST_IDLE) && (wd_q == WW'(TIMEOUT - 1));
    assign err_o  = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= wd_hit;
            if (state_q == ST_IDLE) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end
`else
    assign wd_hit = 1'b0;
    assign err_o  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_o;
        done_d     = '0;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        last_d     = last_q;
        start_d    = spi_start_o;
        tx_d       = spi_data_bo;
        rx_d       = data_out_bo;
        if (wd_hit) begin
            state_d = ST_IDLE;
            start_d = 1'b0;
            gnt_d   = '0;
            lock_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lock_drop) begin
                        lock_d = 1'b0;
                        ptr_d  = lock_idx_q;
                    end
                    if (win_any) begin
                        gnt_d   = win_gnt;
                        owner_d = win_idx;
                        tx_d    = data_in_bi[win_idx*DATA_W +: DATA_W];
                        last_d  = last_i[win_idx];
                        start_d = 1'b1;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (spi_busy_i) begin
                        start_d = 1'b0;
                        state_d = ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (!spi_busy_i) begin
                        rx_d    = spi_data_bi;
                        done_d  = gnt_o;
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                        // A non-final byte keeps the bus; the final one moves the pointer.
                        if (last_q) begin
                            ptr_d  = owner_q;
                            lock_d = 1'b0;
                        end else begin
                            lock_d     = 1'b1;
                            lock_idx_d = owner_q;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            gnt_o       <= '0;
            done_o      <= '0;
            owner_q     <= '0;
            ptr_q       <= IW'(N_REQ - 1);
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            last_q      <= 1'b0;
            spi_start_o <= 1'b0;
            spi_data_bo <= '0;
            data_out_bo <= '0;
        end else begin
            state_q     <= state_d;
            gnt_o       <= gnt_d;
            done_o      <= done_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            last_q      <= last_d;
            spi_start_o <= start_d;
            spi_data_bo <= tx_d;
            data_out_bo <= rx_d;
        end
    end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_master_driver between N_REQ on-chip requesters, one byte transaction at a time.
- Round-robin grant, with optional multi-byte burst lock so a requester can keep the bus for consecutive bytes.
- Drives the master's start/data inputs and returns its received byte plus a per-requester done pulse.
- Sits between the client blocks (register bridges, sensor pollers) and spi_master_driver.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match spi_master_driver.
- TIMEOUT, 1023, watchdog limit in clk cycles; used only with SPI_ARB_WATCHDOG_EN.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  N_REQ  per-requester transfer request, level.
- last_i  in  N_REQ  per-requester flag: 1 = final byte of burst.
- data_in_bi  in  N_REQ*DATA_W  flattened TX bytes; requester k uses bits [k*DATA_W +: DATA_W].
- gnt_o  out  N_REQ  one-hot, marks the current owner.
- done_o  out  N_REQ  one-cycle pulse to the owner at transfer end.
- data_out_bo  out  DATA_W  last received byte; valid from done_o onward, held until the next done_o.
- err_o  out  1  watchdog abort pulse; tied 0 without the macro.
- spi_start_o  out  1  to master start_i.
- spi_data_bo  out  DATA_W  to master data_in_bi.
- spi_busy_i  in  1  from master busy_o.
- spi_data_bi  in  DATA_W  from master data_out_bo.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Round-robin pointer = N_REQ-1, so requester 0 wins first.
  - Lock cleared.
- IDLE: if any req_i bit is set, choose a winner.
  - Locked owner still requesting: the locked owner wins.
  - Otherwise: the first requesting index after the pointer, cyclically.
  - On the next edge: register gnt_o, latch the winner's data into spi_data_bo, latch its last_i into last_q, go START.
  - Latency: req_i to spi_start_o high = 1 cycle.
- START: spi_start_o=1, held until spi_busy_i=1 is sampled. On that edge: spi_start_o=0, go XFER.
- XFER: wait for spi_busy_i=0. On that edge:
  - data_out_bo <= spi_data_bi.
  - done_o[owner] = 1 for one cycle.
  - gnt_o cleared; go IDLE.
  - If last_q=1: pointer <= owner and lock cleared. Else: lock <= owner.
- Lock release: if the locked owner's req_i is low in IDLE, clear the lock and advance the pointer to that owner. Arbitration proceeds normally in the same cycle.
- Requester contract: hold req_i, data and last_i stable until done_o. A req_i drop mid-transfer is ignored; the transfer completes and done_o still pulses.
- New req_i arriving during START/XFER waits until IDLE. IDLE re-arbitrates in the cycle after done, so there is at most 1 idle cycle between transfers.
- Simultaneous requests: the pointer rule applies; every requester is served within N_REQ grants unless a lock is held.
- Reset mid-transfer: everything returns to reset values immediately. The master driver shares rst_i, so no abort sequencing is needed.
- spi_data_bo holds its value after the transfer; it changes only at grant.

Optional Feature:
- Macro: SPI_ARB_WATCHDOG_EN.
- With the macro:
  - A counter clears on entry to START and increments in START/XFER.
  - Reaching TIMEOUT forces IDLE, clears spi_start_o, gnt_o and the lock, and pulses err_o for 1 cycle.
  - No done_o is issued and data_out_bo is unchanged.
- Without the macro: no counter; err_o tied 0; a stuck spi_busy_i hangs the arbiter.

Decomposition:
- Package spi_arb_pkg: state encoding (IDLE, START, XFER); DATA_W default; N_REQ bounds.
- One sub-module, spi_rr_pick: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, index, any.
  - Reused by the top for both the lock and the normal path.

Test Plan:
- Single request:
  - Stimulus: req_i=0001, data0=8'hAC; slave model returns 8'hA5.
  - Response: spi_start_o rises 1 cycle after req; done_o=0001 exactly once; data_out_bo=8'hA5; spi_data_bo=8'hAC.
- Simultaneous requests from reset:
  - Stimulus: req_i=1111 held, all last=1.
  - Response: grant order 0,1,2,3,0; exactly one gnt_o bit ever set.
- Burst lock:
  - Stimulus: req 1 with last=0,0,1 over 3 bytes; req 2 constantly high.
  - Response: bytes granted 1,1,1, then 2.
- Lock release on drop:
  - Stimulus: req 3 last=0, then req 3 dropped after done.
  - Response: lock cleared; the next grant goes to req 0 per pointer=3.
- Reset mid-XFER:
  - Stimulus: assert rst_i for 1 cycle during busy.
  - Response: all outputs 0 next cycle; no done_o; requester 0 granted first afterwards.
- Watchdog (macro defined, TIMEOUT=20):
  - Stimulus: spi_busy_i stuck at 1.
  - Response: err_o pulses 1 cycle after 20 cycles in START/XFER; state IDLE; no done_o.
